ultrasonic_ranger: RTL and testbench



---
 rtl/ultrasonic_ranger.sv | 213 +++++++++++++++++++++
 tb/tb_ultrasonic_ranger.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_ranger.sv
// Round-robin driver for N_CH HC-SR04-style ultrasonic sensors.
// Each channel gets a trigger pulse and its echo width is timed in clk cycles.
// The result is reported with a channel tag, a valid strobe and a timeout flag.
// Optional: define ULTRASONIC_RANGER_ECHO_FILTER_EN to add a 4-cycle glitch
// filter on every synchronised echo line.
module ultrasonic_ranger #(
  parameter int N_CH           = 4,
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 1900000,
  parameter int PERIOD_CYCLES  = 3000000,
  parameter int CNT_W          = 22,
  localparam int CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [N_CH-1:0]   echo,
  output logic [N_CH-1:0]   trigger,
  output logic [CNT_W-1:0]  dist_cycles,
  output logic [CH_W-1:0]   dist_ch,
  output logic              dist_valid,
  output logic              dist_timeout,
  output logic              busy
);

  localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CH_W-1:0]  CH_LAST      = CH_W'(N_CH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_HOLDOFF
  } state_t;

  state_t             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   per_q, per_d;
  logic [CNT_W-1:0]   dist_cycles_q, dist_cycles_d;
  logic [CH_W-1:0]    dist_ch_q, dist_ch_d;
  logic               dist_valid_q, dist_valid_d;
  logic               dist_timeout_q, dist_timeout_d;

  logic [N_CH-1:0]    echo_meta_q, echo_sync_q, echo_prev_q;
  logic [N_CH-1:0]    echo_lvl;
  logic               echo_cur, echo_rise;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Two-flop synchroniser on every echo line plus a registered copy of the
  // measured level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_meta_q <= '0;
      echo_sync_q <= '0;
      echo_prev_q <= '0;
    end else begin
      echo_meta_q <= echo;
      echo_sync_q <= echo_meta_q;
      echo_prev_q <= echo_lvl;
    end
  end

`ifdef ULTRASONIC_RANGER_ECHO_FILTER_EN
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_filt
    logic       filt_q, filt_d;
    logic [1:0] hold_q, hold_d;

    // Accept a new level only after it has been stable for 4 cycles.
    always_comb begin
      filt_d = filt_q;
      hold_d = 2'd0;
      if (echo_sync_q[gi] != filt_q) begin
        if (hold_q == 2'd3) begin
          filt_d = echo_sync_q[gi];
        end else begin
          hold_d = hold_q + 2'd1;
        end
      end
    end

    // Filter state register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        filt_q <= 1'b0;
        hold_q <= 2'd0;
      end else begin
        filt_q <= filt_d;
        hold_q <= hold_d;
      end
    end

    assign echo_lvl[gi] = filt_q;
  end
`else
  assign echo_lvl = echo_sync_q;
`endif

  // Only the selected channel is ever looked at.
  assign echo_cur  = echo_lvl[ch_q];
  assign echo_rise = echo_cur & ~echo_prev_q[ch_q];

  // Next-state, counters and result fields.
  always_comb begin
    state_d        = state_q;
    ch_d           = ch_q;
    cnt_d          = cnt_q;
    per_d          = sat_inc(per_q);
    dist_cycles_d  = dist_cycles_q;
    dist_ch_d      = dist_ch_q;
    dist_valid_d   = 1'b0;
    dist_timeout_d = dist_timeout_q;
    case (state_q)
      ST_IDLE: begin
        per_d = '0;
        cnt_d = '0;
        if (enable) state_d = ST_TRIG;
      end
      ST_TRIG: begin
        if (cnt_q >= TRIG_LAST) begin
          cnt_d   = '0;
          state_d = ST_WAIT_RISE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_WAIT_RISE: begin
        if (echo_rise) begin
          // The rise cycle is the first high cycle of the pulse.
          cnt_d   = CNT_W'(1);
          state_d = ST_MEASURE;
        end else if (cnt_q >= TIMEOUT_LAST) begin
          dist_valid_d   = 1'b1;
          dist_ch_d      = ch_q;
          dist_cycles_d  = '1;
          dist_timeout_d = 1'b1;
          state_d        = ST_HOLDOFF;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_MEASURE: begin
        if (!echo_cur) begin
          dist_valid_d   = 1'b1;
          dist_ch_d      = ch_q;
          dist_cycles_d  = cnt_q;
          dist_timeout_d = 1'b0;
          state_d        = ST_HOLDOFF;
        end else if (cnt_q >= TIMEOUT_C) begin
          dist_valid_d   = 1'b1;
          dist_ch_d      = ch_q;
          dist_cycles_d  = '1;
          dist_timeout_d = 1'b1;
          state_d        = ST_HOLDOFF;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_HOLDOFF: begin
        if (per_q >= PERIOD_LAST) begin
          per_d   = '0;
          cnt_d   = '0;
          ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
          state_d = enable ? ST_TRIG : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      ch_q           <= '0;
      cnt_q          <= '0;
      per_q          <= '0;
      dist_cycles_q  <= '0;
      dist_ch_q      <= '0;
      dist_valid_q   <= 1'b0;
      dist_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ch_q           <= ch_d;
      cnt_q          <= cnt_d;
      per_q          <= per_d;
      dist_cycles_q  <= dist_cycles_d;
      dist_ch_q      <= dist_ch_d;
      dist_valid_q   <= dist_valid_d;
      dist_timeout_q <= dist_timeout_d;
    end
  end

  // Trigger decoded straight from the state register so reset drops it at once.
  always_comb begin
    trigger = '0;
    if (state_q == ST_TRIG) trigger[ch_q] = 1'b1;
  end

  assign busy         = (state_q != ST_IDLE);
  assign dist_cycles  = dist_cycles_q;
  assign dist_ch      = dist_ch_q;
  assign dist_valid   = dist_valid_q;
  assign dist_timeout = dist_timeout_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Self-checking bench for ultrasonic_ranger with small timing parameters.
module tb_ultrasonic_ranger;
  localparam int N_CH  = 2;
  localparam int TRIG  = 5;
  localparam int TMO   = 100;
  localparam int PER   = 300;
  localparam int CNT_W = 22;
  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [N_CH-1:0]   echo = '0;
  logic [N_CH-1:0]   trigger;
  logic [CNT_W-1:0]  dist_cycles;
  logic [0:0]        dist_ch;
  logic              dist_valid;
  logic              dist_timeout;
  logic              busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int multihot = 0;
  int next_ch  = 0;

  int rise_cyc[$];
  int rise_ch[$];
  int fall_cyc[N_CH];
  int rep_cyc[$];
  int rep_ch[$];
  int rep_to[$];
  logic [CNT_W-1:0] rep_val[$];
  logic [N_CH-1:0] trig_prev = '0;

  always #5 clk = ~clk;

  ultrasonic_ranger #(
    .N_CH(N_CH), .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TMO),
    .PERIOD_CYCLES(PER), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .echo(echo),
    .trigger(trigger), .dist_cycles(dist_cycles), .dist_ch(dist_ch),
    .dist_valid(dist_valid), .dist_timeout(dist_timeout), .busy(busy)
  );

  // Monitor: logs trigger edges and reports, sampled on the falling clock edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if ($countones(trigger) > 1) multihot = multihot + 1;
      for (int i = 0; i < N_CH; i++) begin
        if (trigger[i] === 1'b1 && trig_prev[i] === 1'b0) begin
          rise_cyc.push_back(cyc);
          rise_ch.push_back(i);
        end
        if (trigger[i] === 1'b0 && trig_prev[i] === 1'b1) fall_cyc[i] = cyc;
      end
      trig_prev = trigger;
      if (dist_valid === 1'b1) begin
        rep_cyc.push_back(cyc);
        rep_ch.push_back(int'(dist_ch));
        rep_val.push_back(dist_cycles);
        rep_to.push_back(int'(dist_timeout));
      end
    end
  end

  task automatic wait_trig(input int ch, input logic lvl, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      n = n + 1;
      if (trigger[ch] === lvl) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL wait_trigger%0d_level%0b: got timeout, expected edge within 2000 cycles", ch, lvl);
    end
  endtask

  task automatic pulse(input int ch, input int dly, input int w);
    repeat (dly) @(negedge clk);
    echo[ch] = 1'b1;
    repeat (w) @(negedge clk);
    echo[ch] = 1'b0;
  endtask

  task automatic get_report(output bit ok, output int c, output int ch,
                            output logic [CNT_W-1:0] v, output int to);
    ok = 1'b0; c = 0; ch = 0; v = '0; to = 0;
    for (int i = 0; i < 2000; i++) begin
      if (rep_cyc.size() > 0) begin
        c  = rep_cyc.pop_front();
        ch = rep_ch.pop_front();
        v  = rep_val.pop_front();
        to = rep_to.pop_front();
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!ok) $display("FAIL report_arrival: got none, expected a report within 2000 cycles");
    else n_pass++;
  endtask

  task automatic clear_reports();
    rep_cyc.delete(); rep_ch.delete(); rep_val.delete(); rep_to.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; echo = '0;
    repeat (5) @(negedge clk);
    n_checks++; if (trigger !== '0) $display("FAIL reset_trigger: got %b expected 00", trigger); else n_pass++;
    n_checks++; if (dist_cycles !== '0) $display("FAIL reset_dist_cycles: got %0d expected 0", dist_cycles); else n_pass++;
    n_checks++; if (dist_ch !== '0) $display("FAIL reset_dist_ch: got %0d expected 0", dist_ch); else n_pass++;
    n_checks++; if (dist_valid !== 1'b0) $display("FAIL reset_dist_valid: got %b expected 0", dist_valid); else n_pass++;
    n_checks++; if (dist_timeout !== 1'b0) $display("FAIL reset_dist_timeout: got %b expected 0", dist_timeout); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy); else n_pass++;
    $display("reset: outputs checked in reset and idle");
  endtask

  task automatic test_first_measure();
    int n; bit ok; int c; int ch; int to; logic [CNT_W-1:0] v;
    clear_reports();
    enable = 1'b1;
    wait_trig(0, 1'b1, n, ok);
    wait_trig(0, 1'b0, n, ok);
    n_checks++; if (n != TRIG) $display("FAIL trig_width: got %0d expected %0d", n, TRIG); else n_pass++;
    pulse(0, 20, 40);
    get_report(ok, c, ch, v, to);
    n_checks++; if (ch != 0) $display("FAIL first_ch: got %0d expected 0", ch); else n_pass++;
    n_checks++; if (v !== CNT_W'(40)) $display("FAIL first_cycles: got %0d expected 40", v); else n_pass++;
    n_checks++; if (to != 0) $display("FAIL first_timeout: got %0d expected 0", to); else n_pass++;
    repeat (20) @(negedge clk);
    n_checks++; if (rep_cyc.size() != 0) $display("FAIL first_single: got %0d extra reports expected 0", rep_cyc.size()); else n_pass++;
    $display("first_measure: ch=%0d cycles=%0d timeout=%0d", ch, v, to);
  endtask

  task automatic test_no_echo();
    int n; bit ok; int c; int ch; int to; int lat; logic [CNT_W-1:0] v;
    wait_trig(1, 1'b1, n, ok);
    wait_trig(1, 1'b0, n, ok);
    get_report(ok, c, ch, v, to);
    lat = c - fall_cyc[1];
    n_checks++; if (lat < TMO || lat > TMO + 2) $display("FAIL noecho_latency: got %0d expected %0d..%0d", lat, TMO, TMO + 2); else n_pass++;
    n_checks++; if (ch != 1) $display("FAIL noecho_ch: got %0d expected 1", ch); else n_pass++;
    n_checks++; if (to != 1) $display("FAIL noecho_timeout: got %0d expected 1", to); else n_pass++;
    n_checks++; if (v !== ALL_ONES) $display("FAIL noecho_cycles: got %0h expected %0h", v, ALL_ONES); else n_pass++;
    $display("no_echo: ch=%0d latency=%0d timeout=%0d", ch, lat, to);
  endtask

  task automatic test_round_robin();
    int n; bit ok; int c; int ch; int to; int mode; int dly; int w;
    int exp_to; logic [CNT_W-1:0] v; logic [CNT_W-1:0] exp_v;
    rise_cyc.delete(); rise_ch.delete();
    next_ch = 0;
    for (int k = 0; k < 6; k++) begin
      wait_trig(next_ch, 1'b1, n, ok);
      wait_trig(next_ch, 1'b0, n, ok);
      mode = $urandom_range(0, 3);
      dly  = $urandom_range(5, 60);
      w    = (mode == 3) ? $urandom_range(110, 160) : $urandom_range(1, 90);
      if (mode != 2) pulse(next_ch, dly, w);
      // Reference: a pulse no wider than the limit reports its width, anything else times out.
      if (mode == 2 || w > TMO) begin exp_v = ALL_ONES; exp_to = 1; end
      else begin exp_v = CNT_W'(w); exp_to = 0; end
      get_report(ok, c, ch, v, to);
      n_checks++; if (ch != next_ch) $display("FAIL rr_ch: got %0d expected %0d", ch, next_ch); else n_pass++;
      n_checks++; if (v !== exp_v) $display("FAIL rr_cycles: got %0d expected %0d", v, exp_v); else n_pass++;
      n_checks++; if (to != exp_to) $display("FAIL rr_timeout: got %0d expected %0d", to, exp_to); else n_pass++;
      $display("round_robin: ch=%0d mode=%0d width=%0d cycles=%0d timeout=%0d", ch, mode, w, v, to);
      next_ch = (next_ch + 1) % N_CH;
    end
    n_checks++; if (rise_cyc.size() < 6) $display("FAIL rr_rise_count: got %0d expected >=6", rise_cyc.size()); else n_pass++;
    if (rise_ch.size() > 0) begin
      n_checks++; if (rise_ch[0] != 0) $display("FAIL rr_first_ch: got %0d expected 0", rise_ch[0]); else n_pass++;
    end
    for (int i = 1; i < rise_cyc.size(); i++) begin
      n_checks++; if (rise_cyc[i] - rise_cyc[i-1] != PER) $display("FAIL rr_period: got %0d expected %0d", rise_cyc[i] - rise_cyc[i-1], PER); else n_pass++;
      n_checks++; if (rise_ch[i] != (rise_ch[0] + i) % N_CH) $display("FAIL rr_order: got %0d expected %0d", rise_ch[i], (rise_ch[0] + i) % N_CH); else n_pass++;
    end
  endtask

  task automatic test_overlong();
    int n; bit ok; int c; int ch; int to; int lat; logic [CNT_W-1:0] v;
    wait_trig(0, 1'b1, n, ok);
    wait_trig(0, 1'b0, n, ok);
    clear_reports();
    pulse(0, 10, 150);
    get_report(ok, c, ch, v, to);
    lat = c - fall_cyc[0];
    n_checks++; if (to != 1) $display("FAIL overlong_timeout: got %0d expected 1", to); else n_pass++;
    n_checks++; if (v !== ALL_ONES) $display("FAIL overlong_cycles: got %0h expected %0h", v, ALL_ONES); else n_pass++;
    n_checks++; if (ch != 0) $display("FAIL overlong_ch: got %0d expected 0", ch); else n_pass++;
    n_checks++; if (lat < 10 + TMO - 5 || lat > 10 + TMO + 5) $display("FAIL overlong_latency: got %0d expected about %0d", lat, 10 + TMO); else n_pass++;
    repeat (30) @(negedge clk);
    n_checks++; if (rep_cyc.size() != 0) $display("FAIL overlong_second: got %0d extra reports expected 0", rep_cyc.size()); else n_pass++;
    $display("overlong: ch=%0d latency=%0d timeout=%0d", ch, lat, to);
  endtask

  task automatic test_enable_drop();
    int n; bit ok; int c; int ch; int to; int nr; logic [CNT_W-1:0] v;
    wait_trig(0, 1'b1, n, ok);
    wait_trig(0, 1'b0, n, ok);
    clear_reports();
    repeat (10) @(negedge clk);
    echo[0] = 1'b1;
    repeat (10) @(negedge clk);
    enable = 1'b0;
    repeat (20) @(negedge clk);
    echo[0] = 1'b0;
    get_report(ok, c, ch, v, to);
    n_checks++; if (ch != 0) $display("FAIL endrop_ch: got %0d expected 0", ch); else n_pass++;
    n_checks++; if (v !== CNT_W'(30)) $display("FAIL endrop_cycles: got %0d expected 30", v); else n_pass++;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) $display("FAIL endrop_idle: got busy=%b expected 0", busy); else n_pass++;
    nr = rise_cyc.size();
    repeat (400) @(negedge clk);
    n_checks++; if (rise_cyc.size() != nr || busy !== 1'b0) $display("FAIL endrop_stay_idle: got %0d triggers busy=%b expected 0 and 0", rise_cyc.size() - nr, busy); else n_pass++;
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (trigger !== '0) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok || trigger !== 2'b10) $display("FAIL endrop_resume: got %b expected 10", trigger); else n_pass++;
    $display("enable_drop: ch=%0d cycles=%0d resume_trigger=%b", ch, v, trigger);
  endtask

  task automatic test_reset_mid();
    int n; bit ok;
    wait_trig(0, 1'b1, n, ok);
    wait_trig(0, 1'b0, n, ok);
    repeat (10) @(negedge clk);
    echo[0] = 1'b1;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (trigger !== '0) $display("FAIL rstmid_trigger: got %b expected 00", trigger); else n_pass++;
    n_checks++; if (dist_valid !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", dist_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (dist_cycles !== '0) $display("FAIL rstmid_cycles: got %0d expected 0", dist_cycles); else n_pass++;
    clear_reports();
    echo[0] = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (trigger !== '0) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok || trigger !== 2'b01) $display("FAIL rstmid_first_trigger: got %b expected 01", trigger); else n_pass++;
    n_checks++; if (rep_cyc.size() != 0) $display("FAIL rstmid_partial: got %0d reports expected 0", rep_cyc.size()); else n_pass++;
    $display("reset_mid: first trigger after release=%b", trigger);
  endtask

  task automatic test_glitch();
    int n; bit ok; int c; int ch; int to; logic [CNT_W-1:0] v; logic [CNT_W-1:0] exp_v;
`ifdef ULTRASONIC_RANGER_ECHO_FILTER_EN
    exp_v = CNT_W'(30);
`else
    exp_v = CNT_W'(2);
`endif
    wait_trig(0, 1'b0, n, ok);
    clear_reports();
    pulse(0, 10, 2);
    pulse(0, 5, 30);
    get_report(ok, c, ch, v, to);
    n_checks++; if (v !== exp_v) $display("FAIL glitch_cycles: got %0d expected %0d", v, exp_v); else n_pass++;
    n_checks++; if (to != 0) $display("FAIL glitch_timeout: got %0d expected 0", to); else n_pass++;
    repeat (40) @(negedge clk);
    n_checks++; if (rep_cyc.size() != 0) $display("FAIL glitch_second: got %0d extra reports expected 0", rep_cyc.size()); else n_pass++;
    $display("glitch: ch=%0d cycles=%0d", ch, v);
  endtask

  task automatic test_onehot();
    n_checks++; if (multihot != 0) $display("FAIL trigger_onehot: got %0d multi-hot cycles expected 0", multihot); else n_pass++;
    $display("onehot: multi-hot cycles=%0d", multihot);
  endtask

  initial begin
    test_reset();
    test_first_measure();
    test_no_echo();
    test_round_robin();
    test_overlong();
    test_enable_drop();
    test_reset_mid();
    test_glitch();
    test_onehot();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
